m_dmx: RTL and testbench

M_DMX -- requirements
Module: m_dmx

---
 rtl/dm_pkg.sv | 37 +++
 rtl/dm_load_ext.sv | 37 +++
 rtl/m_dmx.sv | 164 ++++++++++++++++
 tb/tb_m_dmx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the m_dmx data memory: access opcodes, controller
// states and the alignment rule used by both the decoder and the pipeline.
package dm_pkg;

   typedef enum logic [2:0] {
      OP_LW  = 3'd0,
      OP_LH  = 3'd1,
      OP_LHU = 3'd2,
      OP_LB  = 3'd3,
      OP_LBU = 3'd4,
      OP_SW  = 3'd5,
      OP_SH  = 3'd6,
      OP_SB  = 3'd7
   } dm_op_e;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } dm_state_e;

   function automatic logic dm_is_load(input logic [2:0] op);
      return (op <= 3'd4);
   endfunction

   // Halfword accesses need an even address, word accesses a multiple of four.
   function automatic logic dm_misaligned(input logic [2:0] op, input logic [1:0] lo);
      logic w_res;
      w_res = 1'b0;
      case (dm_op_e'(op))
         OP_LH, OP_LHU, OP_SH: w_res = lo[0];
         OP_LW, OP_SW:         w_res = (lo != 2'b00);
         default:              w_res = 1'b0;
      endcase
      return w_res;
   endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load formatter: picks the byte/half lane of the fetched word and applies
// sign or zero extension according to the load opcode.
module dm_load_ext
   import dm_pkg::*;
(
   input  logic [2:0]  i_op,
   input  logic [1:0]  i_lane,
   input  logic [31:0] i_word,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_word[7:0];
      case (i_lane)
         2'd0: w_byte = i_word[7:0];
         2'd1: w_byte = i_word[15:8];
         2'd2: w_byte = i_word[23:16];
         2'd3: w_byte = i_word[31:24];
         default: w_byte = i_word[7:0];
      endcase
      w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

      o_data = '0;
      case (dm_op_e'(i_op))
         OP_LW:   o_data = i_word;
         OP_LH:   o_data = {{16{w_half[15]}}, w_half};
         OP_LHU:  o_data = {16'h0000, w_half};
         OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
         OP_LBU:  o_data = {24'h000000, w_byte};
         default: o_data = '0;
      endcase
   end

endmodule

// File: rtl/m_dmx.sv
// Byte-addressed data memory with a post-reset zeroing sweep and a
// READ_LAT-deep load pipeline. Define DM_TRACE_EN to log every performed store.
module m_dmx
   import dm_pkg::*;
#(
   parameter int DEPTH_WORDS = 4096,
   parameter int READ_LAT    = 1
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        req,
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        rvalid,
   output logic        misalign,
   output logic        busy,
   output logic        o_dbg_state
);

   localparam int ADDR_W = $clog2(DEPTH_WORDS);

   dm_state_e         r_state;
   dm_state_e         w_next;
   logic [ADDR_W-1:0] r_clr_idx;
   logic [31:0]       r_mem [DEPTH_WORDS];

   logic              w_accept;
   logic              w_mis;
   logic              w_ld;
   logic              w_st;
   logic [ADDR_W-1:0] w_idx;
   logic [3:0]        w_be;
   logic [31:0]       w_wsh;
   logic              w_unused;

   // Handshake: a request is taken on any rising edge where req=1, reset=0 and
   // the sweep is finished; there is no backpressure, dropped requests are lost.
   assign w_idx    = addr[ADDR_W+1:2];
   assign w_accept = req && !reset && (r_state == ST_IDLE);
   assign w_mis    = dm_misaligned(op, addr[1:0]);
   assign w_ld     = w_accept && !w_mis && dm_is_load(op);
   assign w_st     = w_accept && !w_mis && !dm_is_load(op);
   assign w_unused = ^{pc, addr[31:ADDR_W+2]};

   always_comb begin
      w_be  = 4'b0000;
      w_wsh = '0;
      case (dm_op_e'(op))
         OP_SW: begin
            w_be  = 4'b1111;
            w_wsh = wdata;
         end
         OP_SH: begin
            w_be  = addr[1] ? 4'b1100 : 4'b0011;
            w_wsh = {2{wdata[15:0]}};
         end
         OP_SB: begin
            w_be  = 4'b0001 << addr[1:0];
            w_wsh = {4{wdata[7:0]}};
         end
         default: begin
            w_be  = 4'b0000;
            w_wsh = '0;
         end
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_CLEAR: if (r_clr_idx == ADDR_W'(DEPTH_WORDS - 1)) w_next = ST_IDLE;
         ST_IDLE:  w_next = ST_IDLE;
         default:  w_next = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_CLEAR;
         r_clr_idx <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_CLEAR) r_clr_idx <= r_clr_idx + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && (r_state == ST_CLEAR)) begin
         r_mem[r_clr_idx] <= '0;
      end else if (w_st) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wsh[8*b +: 8];
         end
      end
   end

   // Load pipeline: stage 0 captures the raw word at the accepting edge; the
   // lane/extension logic only sees the last stage.
   logic        r_pv    [READ_LAT];
   logic [31:0] r_pd    [READ_LAT];
   logic [2:0]  r_pop   [READ_LAT];
   logic [1:0]  r_plane [READ_LAT];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < READ_LAT; i++) r_pv[i] <= 1'b0;
      end else begin
         r_pv[0] <= w_ld;
         for (int i = 1; i < READ_LAT; i++) r_pv[i] <= r_pv[i-1];
      end
   end

   always_ff @(posedge clk) begin
      r_pd[0]    <= r_mem[w_idx];
      r_pop[0]   <= op;
      r_plane[0] <= addr[1:0];
      for (int i = 1; i < READ_LAT; i++) begin
         r_pd[i]    <= r_pd[i-1];
         r_pop[i]   <= r_pop[i-1];
         r_plane[i] <= r_plane[i-1];
      end
   end

   logic [31:0] w_ext;

   dm_load_ext u_load_ext (
      .i_op   (r_pop[READ_LAT-1]),
      .i_lane (r_plane[READ_LAT-1]),
      .i_word (r_pd[READ_LAT-1]),
      .o_data (w_ext)
   );

   logic r_mis;

   always_ff @(posedge clk) begin
      if (reset) r_mis <= 1'b0;
      else       r_mis <= w_accept && w_mis;
   end

   assign rvalid      = r_pv[READ_LAT-1];
   assign rdata       = rvalid ? w_ext : '0;
   assign misalign    = r_mis;
   assign busy        = (r_state == ST_CLEAR);
   assign o_dbg_state = r_state;

`ifdef DM_TRACE_EN
   logic [31:0] w_wmask;
   logic [31:0] w_merged;

   always_comb begin
      w_wmask  = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
      w_merged = (r_mem[w_idx] & ~w_wmask) | (w_wsh & w_wmask);
   end

   always_ff @(posedge clk) begin
      if (w_st) $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, w_merged);
   end
`endif

endmodule

// File: tb/tb_m_dmx.sv
// Self-checking bench for m_dmx: directed scenarios plus random traffic, with
// a reference memory model feeding expected-result queues.
module tb_m_dmx;

   localparam int DEPTH = 64;
   localparam int RL    = 3;
   localparam int IDXW  = 6;

   logic        clk;
   logic        reset;
   logic [31:0] pc;
   logic        req;
   logic [2:0]  op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rvalid;
   logic        misalign;
   logic        busy;
   logic        dbg_state;

   m_dmx #(.DEPTH_WORDS(DEPTH), .READ_LAT(RL)) dut (
      .clk         (clk),
      .reset       (reset),
      .pc          (pc),
      .req         (req),
      .op          (op),
      .addr        (addr),
      .wdata       (wdata),
      .rdata       (rdata),
      .rvalid      (rvalid),
      .misalign    (misalign),
      .busy        (busy),
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // scoreboard state
   logic [31:0] exp_q[$];
   int          exp_t_q[$];
   int          mis_q[$];
   logic [31:0] mdl [DEPTH];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic        mon_en  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic ref_mis(input logic [2:0] o, input logic [31:0] a);
      if ((o == 3'd1 || o == 3'd2 || o == 3'd6) && a[0]) return 1'b1;
      if ((o == 3'd0 || o == 3'd5) && (a[1:0] != 2'b00)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] o, input logic [31:0] a);
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      w = mdl[a[IDXW+1:2]];
      case (a[1:0])
         2'd0: b = w[7:0];
         2'd1: b = w[15:8];
         2'd2: b = w[23:16];
         default: b = w[31:24];
      endcase
      h = a[1] ? w[31:16] : w[15:0];
      case (o)
         3'd0: return w;
         3'd1: return {{16{h[15]}}, h};
         3'd2: return {16'h0, h};
         3'd3: return {{24{b[7]}}, b};
         3'd4: return {24'h0, b};
         default: return 32'h0;
      endcase
   endfunction

   function automatic void ref_store(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] w;
      w = mdl[a[IDXW+1:2]];
      if (o == 3'd5) w = d;
      else if (o == 3'd6) begin
         if (a[1]) w[31:16] = d[15:0];
         else      w[15:0]  = d[15:0];
      end else if (o == 3'd7) begin
         case (a[1:0])
            2'd0: w[7:0]   = d[7:0];
            2'd1: w[15:8]  = d[7:0];
            2'd2: w[23:16] = d[7:0];
            default: w[31:24] = d[7:0];
         endcase
      end
      mdl[a[IDXW+1:2]] = w;
   endfunction

   // driver tasks
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_ld);
      @(posedge clk);
      #1;
      req   = 1'b1;
      op    = o;
      addr  = a;
      wdata = d;
      pc    = pc + 32'd4;
      if (ref_mis(o, a)) mis_q.push_back(cyc + 1);
      else if (o <= 3'd4) begin
         exp_q.push_back(exp_ld);
         exp_t_q.push_back(cyc + RL);
      end else ref_store(o, a, d);
   endtask

   task automatic load(input logic [2:0] o, input logic [31:0] a, input logic [31:0] exp_ld);
      issue(o, a, 32'h0, exp_ld);
   endtask

   task automatic store(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
      issue(o, a, d, 32'h0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         req = 1'b0;
      end
   endtask

   // Reset, check the reset state, then hold a store request through the whole
   // sweep: it must be dropped.
   task automatic do_reset(input int n);
      int cnt;
      @(posedge clk);
      #1;
      reset = 1'b1;
      req   = 1'b0;
      exp_q.delete();
      exp_t_q.delete();
      mis_q.delete();
      mon_en = 1'b1;
      for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
      repeat (n) @(posedge clk);
      #1;
      check("rst_busy", {31'h0, busy}, 32'h1);
      check("rst_rvalid", {31'h0, rvalid}, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_misalign", {31'h0, misalign}, 32'h0);
      check("rst_state", {31'h0, dbg_state}, 32'h0);
      reset = 1'b0;
      req   = 1'b1;
      op    = 3'd5;
      addr  = 32'h0;
      wdata = 32'hDEADBEEF;
      cnt   = 0;
      @(negedge clk);
      while (busy === 1'b1 && cnt < 4 * DEPTH) begin
         cnt++;
         @(negedge clk);
      end
      req = 1'b0;
      check("busy_len", 32'(cnt), 32'(DEPTH));
      check("idle_state", {31'h0, dbg_state}, 32'h1);
   endtask

   // output monitor
   always @(negedge clk) begin
      if (mon_en) begin
         if (rvalid) begin
            if (exp_q.size() == 0) check("unexp_rvalid", 32'h1, 32'h0);
            else begin
               check("rdata", rdata, exp_q.pop_front());
               check("rvalid_cycle", 32'(cyc), 32'(exp_t_q.pop_front()));
            end
         end else begin
            check("rdata_idle", rdata, 32'h0);
         end
         if (misalign) begin
            if (mis_q.size() == 0) check("unexp_misalign", 32'h1, 32'h0);
            else check("misalign_cycle", 32'(cyc), 32'(mis_q.pop_front()));
         end
      end
   end

   initial begin
      logic [2:0]  o;
      logic [31:0] a;
      logic [31:0] d;
      reset = 1'b1;
      req   = 1'b0;
      op    = 3'd0;
      addr  = 32'h0;
      wdata = 32'h0;
      pc    = 32'h1000;
      repeat (2) @(posedge clk);
      do_reset(1);

      // memory reads as zero after the sweep, including wrapped addresses
      load(3'd0, 32'h0000_0000, 32'h0000_0000);
      load(3'd0, 32'h0000_00FC, 32'h0000_0000);
      load(3'd0, 32'hABCD_EF40, 32'h0000_0000);

      // word store then lane/extension loads, first one on the very next cycle
      store(3'd5, 32'h10, 32'h8899AABB);
      load(3'd3, 32'h13, 32'hFFFFFF88);
      load(3'd4, 32'h10, 32'h000000BB);
      load(3'd1, 32'h12, 32'hFFFF8899);
      load(3'd2, 32'h10, 32'h0000AABB);
      load(3'd0, 32'h10, 32'h8899AABB);

      // partial stores
      store(3'd7, 32'h21, 32'h0000007F);
      load(3'd0, 32'h20, 32'h00007F00);
      store(3'd6, 32'h26, 32'h1234ABCD);
      load(3'd0, 32'h24, 32'hABCD0000);
      load(3'd2, 32'h26, 32'h0000ABCD);
      load(3'd3, 32'h27, 32'hFFFFFFAB);
      load(3'd4, 32'h25, 32'h00000000);

      // back-to-back loads
      store(3'd5, 32'h40, 32'h11111111);
      store(3'd5, 32'h44, 32'h22222222);
      store(3'd5, 32'h48, 32'h33333333);
      store(3'd5, 32'h4C, 32'h44444444);
      idle(2);
      load(3'd0, 32'h40, 32'h11111111);
      load(3'd0, 32'h44, 32'h22222222);
      load(3'd0, 32'h48, 32'h33333333);
      load(3'd0, 32'h4C, 32'h44444444);
      idle(RL + 1);

      // misaligned requests: no write, no rvalid, one misalign pulse each
      store(3'd5, 32'h30, 32'hCAFEF00D);
      store(3'd6, 32'h31, 32'h0000FFFF);
      load(3'd0, 32'h22, 32'h0);
      load(3'd1, 32'h33, 32'h0);
      store(3'd5, 32'h32, 32'h12345678);
      load(3'd0, 32'h30, 32'hCAFEF00D);
      load(3'd0, 32'h20, 32'h00007F00);
      idle(RL + 1);

      // random traffic, full 32-bit addresses so the index wraps
      for (int i = 0; i < 300; i++) begin
         o = 3'($urandom_range(0, 7));
         a = $urandom;
         d = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (o == 3'd0 || o == 3'd5) a[1:0] = 2'b00;
            else if (o == 3'd1 || o == 3'd2 || o == 3'd6) a[0] = 1'b0;
         end
         issue(o, a, d, ref_load(o, a));
      end
      idle(RL + 2);

      // reset with loads in flight, then a store dropped during the sweep
      store(3'd5, 32'h50, 32'h5555AAAA);
      load(3'd0, 32'h50, 32'h5555AAAA);
      load(3'd0, 32'h50, 32'h5555AAAA);
      do_reset(1);
      load(3'd0, 32'h50, 32'h00000000);
      load(3'd0, 32'h00, 32'h00000000);
      idle(RL + 3);

      check("drain_rvalid", 32'(exp_q.size()), 32'h0);
      check("drain_misalign", 32'(mis_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
